// File: rtl/para_pkg.sv
// para_pkg: shared compute-type and feeder FSM state definitions
package params;
  typedef enum logic [1:0] {ADDR_FP32, ADDR_FP16, ADDR_INT4} addrgen_t;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;
endpackage

// File: rtl/skew_delay.sv
// skew_delay: DEPTH-stage data+enable delay line, data zeroed when not enabled
module skew_delay #(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  input  logic        en,
  output logic [31:0] q,
  output logic        q_en
);
  logic [DEPTH-1:0][31:0] dq;
  logic [DEPTH-1:0]       eq;
  // shift beat and its enable one stage per cycle; an idle slot carries zero data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dq <= '0;
      eq <= '0;
    end else begin
      dq[0] <= en ? d : 32'h0;
      eq[0] <= en;
      for (int i = 1; i < DEPTH; i++) begin
        dq[i] <= dq[i-1];
        eq[i] <= eq[i-1];
      end
    end
  end
  assign q    = dq[DEPTH-1];
  assign q_en = eq[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts tile beats and skews lane i by i+1 cycles onto the array edges
module systolic_feeder
  import params::*;
#(
  parameter int N    = 4,
  parameter int KMAX = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(KMAX+1)-1:0]   k_len,
  input  addrgen_t                    addr_type_in,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [32*N-1:0]             s_a,
  input  logic [32*N-1:0]             s_b,
  output logic [32*N-1:0]             a_left,
  output logic [N-1:0]                enleft,
  output logic [32*N-1:0]             b_top,
  output logic [N-1:0]                enup,
  output addrgen_t                    addr_type_out,
  output logic                        busy,
  output logic                        done
);
  localparam int KW = $clog2(KMAX+1);
  localparam int FW = $clog2(N+1);
  feeder_state_t state;
  logic [KW-1:0] klen, cnt;
  logic [FW-1:0] fcnt;
  logic acc;
  assign s_ready = (state == STREAM) && (cnt < klen);
  assign busy    = state != IDLE;
  assign acc     = s_valid && s_ready;
  // tile sequencing: capture, count accepted beats, then drain the skew lanes for N cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      klen          <= '0;
      cnt           <= '0;
      fcnt          <= '0;
      addr_type_out <= ADDR_FP32;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && k_len != '0) begin
            klen          <= k_len;
            addr_type_out <= addr_type_in;
            cnt           <= '0;
            state         <= STREAM;
          end else if (start) begin
            done <= 1'b1;
          end
        end
        STREAM: begin
          if (acc) begin
            cnt <= cnt + KW'(1);
            if (cnt + KW'(1) == klen) begin
              fcnt  <= '0;
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (fcnt == FW'(N-1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay #(.DEPTH(i+1)) u_a (
      .clk(clk), .rst(rst), .d(s_a[32*i+:32]), .en(acc),
      .q(a_left[32*i+:32]), .q_en(enleft[i])
    );
    skew_delay #(.DEPTH(i+1)) u_b (
      .clk(clk), .rst(rst), .d(s_b[32*i+:32]), .en(acc),
      .q(b_top[32*i+:32]), .q_en(enup[i])
    );
  end
endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 4: array edge width (lanes per side).
REQ-002 SHALL have parameter KMAX, default 16: maximum beats per tile.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port start  input  1  begin tile; sampled only in IDLE.
REQ-006 SHALL have port k_len  input  $clog2(KMAX+1)  beats in tile; sampled with start.
REQ-007 SHALL have port addr_type_in  input  params::addrgen_t  tile compute type; sampled with start.
REQ-008 SHALL have port s_valid  input  1  source beat valid.
REQ-009 SHALL have port s_ready  output  1  feeder accepts beat.
REQ-010 SHALL have port s_a  input  32*N  lane i = A[i][k], bits [32i+31:32i].
REQ-011 SHALL have port s_b  input  32*N  lane j = B[k][j].
REQ-012 SHALL have port a_left  output  32*N  west-edge data, lane i to row i.
REQ-013 SHALL have port enleft  output  N  west-edge enable per row.
REQ-014 SHALL have port b_top  output  32*N  north-edge data, lane j to column j.
REQ-015 SHALL have port enup  output  N  north-edge enable per column.
REQ-016 SHALL have port addr_type_out  output  params::addrgen_t  captured compute type.
REQ-017 SHALL have port busy  output  1  high outside IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at tile end.

Function
REQ-019 SHALL implement FSM states IDLE, STREAM, FLUSH.
REQ-020 In IDLE, start=1 with k_len>0 SHALL capture k_len and addr_type_in and enter STREAM next cycle.
REQ-021 In IDLE, start=1 with k_len=0 SHALL pulse done next cycle and remain IDLE.
REQ-022 start outside IDLE SHALL be ignored; k_len/addr_type_in changes while busy SHALL be ignored.
REQ-023 s_ready SHALL be 1 only in STREAM while accepted count < captured k_len.
REQ-024 A beat SHALL be accepted when s_valid and s_ready are both 1; accepted count increments by 1.
REQ-025 Lane i (a and b alike) of an accepted beat SHALL appear on its output exactly i+1 cycles after acceptance, with its enable bit high for that one cycle.
REQ-026 A STREAM cycle with s_valid=0 SHALL be a bubble: enable low for that slot on every lane, skew preserved.
REQ-027 Any output lane whose enable is low SHALL drive data 32'h0.
REQ-028 On accepting beat k_len, the FSM SHALL enter FLUSH and stay there exactly N cycles, draining all delay lanes.
REQ-029 On leaving FLUSH, done SHALL pulse for one cycle and the FSM SHALL return to IDLE; start in that same cycle SHALL be honored.
REQ-030 addr_type_out SHALL hold the captured value from STREAM entry until the next capture.
REQ-031 Beat data SHALL pass unmodified; datatype (FP32/FP16/INT4) does not alter lane packing.

Reset
REQ-032 While rst=0: state=IDLE, counters=0, delay lanes cleared, s_ready=0, enleft=0, enup=0, a_left=0, b_top=0, addr_type_out=0, busy=0, done=0.
REQ-033 Reset asserted mid-tile SHALL abandon the tile with no done pulse; partial beats are not emitted after release.

Structure
REQ-034 The FSM state enum SHALL be defined in para_pkg (package params), alongside existing addrgen_t.
REQ-035 Per-lane skew SHALL use one sub-module skew_delay (parameter DEPTH; data + enable delay line, async active-low reset), instantiated 2N times.

Verification
REQ-036 N=4, k_len=3, s_valid always 1, s_a lanes = {8'hk,lane} -> enleft[0] high cycles 1-3 after first accept, enleft[3] cycles 4-6; done 1 cycle after FLUSH's 4 cycles.
REQ-037 k_len=4 with s_valid low on 2nd cycle -> one-slot gap in each lane's enable, shifted by lane index; a_left=0 in gap; 4 beats total emitted per lane.
REQ-038 start with k_len=0 -> done pulses next cycle, busy stays 0, no enables.
REQ-039 start pulsed again during STREAM with different addr_type_in -> ignored; addr_type_out unchanged, beat count unchanged.
REQ-040 rst=0 asynchronously after 2 of 5 beats -> all outputs 0 immediately; after release, IDLE, no done, no stale enables.
REQ-041 start asserted in the done cycle -> second tile begins STREAM next cycle with newly captured k_len.
